// File: rtl/rain_column_scheduler.sv
// rtl/rain_column_scheduler.sv - per-column glyph-rain state engine with registered lookup
//
// Holds one record {on, speed[1:0], len[3:0], head[5:0]} per 8-pixel character
// column. After reset every record is seeded from a 16-bit Galois LFSR (INIT).
// Each frame_start accepted in IDLE runs one read-modify-write SCAN over all
// columns. A column respawns at the top with freshly rolled fields once its trail
// has left the screen.
//
// Optional feature macro: RAIN_PAUSE_EN adds the pause input. A scan started
// with pause=1 keeps its normal timing but writes nothing.
//
// Ports:
//   clk          pixel clock
//   rst_n        synchronous active-low reset; restarts INIT
//   frame_start  one-cycle start-of-vertical-blank pulse
//   pause        (RAIN_PAUSE_EN only) suppress writes for the scan being started
//   rd_col       column index to look up
//   rd_head      registered head row of rd_col (0 when rd_col >= NUM_COLS)
//   rd_len       registered trail length of rd_col (0 when out of range)
//   rd_on        registered visibility of rd_col (0 when out of range)
//   busy         INIT or SCAN in progress
//   done         one-cycle pulse after the last entry of a scan is written
//   overrun      high in the same cycle as a frame_start that arrives while busy
module rain_column_scheduler #(
  parameter int          NUM_COLS  = 80,
  parameter int          ROWS      = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
`ifdef RAIN_PAUSE_EN
  input  logic       pause,
`endif
  input  logic [6:0] rd_col,
  output logic [5:0] rd_head,
  output logic [3:0] rd_len,
  output logic       rd_on,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam logic [6:0] LAST_IDX = 7'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t      r_state;
  logic [12:0] r_mem [NUM_COLS];
  logic [6:0]  r_idx;
  logic [15:0] r_lfsr;
  logic [2:0]  r_frame_cnt;
  logic        r_busy;
  logic        r_done;
  logic [5:0]  r_rd_head;
  logic [3:0]  r_rd_len;
  logic        r_rd_on;

  logic [15:0] w_lfsr_next;
  logic [6:0]  w_roll_fields;
  logic [12:0] w_init_entry;
  logic [12:0] w_cur;
  logic [6:0]  w_head_inc;
  logic [6:0]  w_limit;
  logic        w_respawn;
  logic [12:0] w_scan_entry;
  logic        w_advance;
  logic        w_last;
  logic        w_scan_wr;

  assign w_lfsr_next   = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  // {on, speed, len}; len is forced into 4..15 so trails are never too short
  assign w_roll_fields = {r_lfsr[7] | r_lfsr[6], r_lfsr[5:4], r_lfsr[3:0] | 4'b0100};
  assign w_init_entry  = {w_roll_fields, 1'b0, r_lfsr[12:8]};

  assign w_cur        = r_mem[r_idx];
  // 7-bit compare: the trail must fully leave the screen before the respawn
  assign w_head_inc   = {1'b0, w_cur[5:0]} + 7'd1;
  assign w_limit      = 7'(ROWS) + {3'b000, w_cur[9:6]};
  assign w_respawn    = (w_head_inc >= w_limit);
  assign w_scan_entry = w_respawn ? {w_roll_fields, 6'd0} : {w_cur[12:6], w_head_inc[5:0]};
  assign w_last       = (r_idx == LAST_IDX);

  // Speed class s steps the column on frames where frame_cnt is a multiple of 2^s
  always_comb begin
    w_advance = 1'b1;
    case (w_cur[11:10])
      2'd0: w_advance = 1'b1;
      2'd1: w_advance = ~r_frame_cnt[0];
      2'd2: w_advance = (r_frame_cnt[1:0] == 2'd0);
      2'd3: w_advance = (r_frame_cnt == 3'd0);
      default: w_advance = 1'b1;
    endcase
  end

`ifdef RAIN_PAUSE_EN
  logic r_pause;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pause <= 1'b0;
    end else if (r_state == ST_IDLE && frame_start) begin
      r_pause <= pause;
    end
  end
  assign w_scan_wr = ~r_pause;
`else
  assign w_scan_wr = 1'b1;
`endif

  // Record storage: not reset, INIT re-seeds every entry after any reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == ST_INIT) begin
        r_mem[r_idx] <= w_init_entry;
      end else if (r_state == ST_SCAN && w_scan_wr && w_advance) begin
        r_mem[r_idx] <= w_scan_entry;
      end
    end
  end

  // Lookup port: a same-cycle write is not forwarded, the old value is returned
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_head <= 6'd0;
      r_rd_len  <= 4'd0;
      r_rd_on   <= 1'b0;
    end else if (rd_col < 7'(NUM_COLS)) begin
      r_rd_head <= r_mem[rd_col][5:0];
      r_rd_len  <= r_mem[rd_col][9:6];
      r_rd_on   <= r_mem[rd_col][12];
    end else begin
      r_rd_head <= 6'd0;
      r_rd_len  <= 4'd0;
      r_rd_on   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_idx       <= 7'd0;
      r_lfsr      <= LFSR_SEED;
      r_frame_cnt <= 3'd0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_lfsr <= w_lfsr_next;
          if (w_last) begin
            r_state <= ST_IDLE;
            r_idx   <= 7'd0;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + 7'd1;
          end
        end
        ST_IDLE: begin
          if (frame_start) begin
            r_state     <= ST_SCAN;
            r_idx       <= 7'd0;
            r_frame_cnt <= r_frame_cnt + 3'd1;
            r_busy      <= 1'b1;
          end
        end
        ST_SCAN: begin
          r_lfsr <= w_lfsr_next;
          if (w_last) begin
            r_state <= ST_IDLE;
            r_idx   <= 7'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 7'd1;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_idx   <= 7'd0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign rd_head = r_rd_head;
  assign rd_len  = r_rd_len;
  assign rd_on   = r_rd_on;
  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = rst_n & frame_start & r_busy;

endmodule
